addsub_serial: RTL

Parametrised, digit-serial adder/subtractor for the SAP datapath. It generalises the fixed four-bit ripple adder to any WIDTH. Operands are processed DIGIT bits per clock through a single ripple slice, with a start/done handshake, an add/subtract mode and optional status flags. The block sits between the accumulator/B registers and the W-bus, as the ALU core.

---
 rtl/alu_pkg.sv | 18 +
 rtl/adder_slice.sv | 33 +++
 rtl/addsub_serial.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the SAP ALU core.
//   addsub_state_t : sequencing states of the digit-serial adder/subtractor
//   ALU_ADD/ALU_SUB: encodings of the SUB mode input
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// Combinational W-bit ripple-carry adder, the single arithmetic slice that
// the serial adder/subtractor reuses on every RUN cycle.
// Ports:
//   A, B  [W-1:0] in   addends
//   C           in   carry-in
//   SUM   [W-1:0] out  A + B + C modulo 2^W
//   CARRY       out  carry-out of the top bit
// ---------------------------------------------------------------------------
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C,
    output logic [W-1:0] SUM,
    output logic         CARRY
);

    logic [W:0] chain;

    assign chain[0] = C;

    // One full adder per bit; the carry ripples up through chain[].
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign SUM[i]     = A[i] ^ B[i] ^ chain[i];
        assign chain[i+1] = (A[i] & B[i]) | (chain[i] & (A[i] ^ B[i]));
    end

    assign CARRY = chain[W];

endmodule

// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
// Digit-serial adder/subtractor (SAP ALU core). Operands are latched on
// START and processed DIGIT bits per clock through one adder_slice; the
// result becomes visible, complete, together with a one-cycle DONE pulse.
// Optional flags: define ADDSUB_FLAGS_EN to register ZF/NF/VF; otherwise
// they are tied to 0 and the ports are kept.
// Parameters: WIDTH (operand width), DIGIT (bits per clock, divides WIDTH)
// Ports:
//   CLK         in   clock, rising edge
//   CLR_N       in   synchronous active-low reset
//   START       in   request, sampled only in IDLE
//   SUB         in   0 = add, 1 = subtract (latched with START)
//   A, B  [W]   in   operands (latched with START)
//   C           in   add carry-in (latched, ignored when subtracting)
//   BUSY        out  high while running
//   DONE        out  one-cycle pulse when SUM/CARRY/flags are new
//   SUM   [W]   out  result, held until the next DONE
//   CARRY       out  carry-out (subtract: 1 = no borrow)
//   ZF, NF, VF  out  zero, negative, signed-overflow flags
// ---------------------------------------------------------------------------
module addsub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             ZF,
    output logic             NF,
    output logic             VF
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("addsub_serial: WIDTH must be a multiple of DIGIT");
    end

    addsub_state_t    state, state_next;
    logic [CW-1:0]    digit_cnt;
    logic [WIDTH-1:0] a_reg, b_reg, result_reg, result_next, sum_reg;
    logic             carry_reg, carry_out_reg;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_carry;
    logic             last_digit;

    assign last_digit = (digit_cnt == CW'(N - 1));

    adder_slice #(.W(DIGIT)) u_slice (
        .A     (a_reg[digit_cnt*DIGIT +: DIGIT]),
        .B     (b_reg[digit_cnt*DIGIT +: DIGIT]),
        .C     (carry_reg),
        .SUM   (slice_sum),
        .CARRY (slice_carry)
    );

    // Current digit merged into the partial result, so the final digit can
    // be published to SUM on the same edge that enters DONE.
    always_comb begin
        result_next = result_reg;
        result_next[digit_cnt*DIGIT +: DIGIT] = slice_sum;
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) state <= alu_pkg::IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            alu_pkg::IDLE: if (START) state_next = alu_pkg::RUN;
            alu_pkg::RUN: begin
                BUSY = 1'b1;
                if (last_digit) state_next = alu_pkg::DONE;
            end
            alu_pkg::DONE: begin
                DONE       = 1'b1;
                state_next = alu_pkg::IDLE;
            end
            default: state_next = alu_pkg::IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the operand inversion and the forced
    // carry-in are folded in at latch time and RUN is mode-agnostic.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            digit_cnt     <= '0;
        end else begin
            case (state)
                alu_pkg::IDLE: begin
                    if (START) begin
                        a_reg      <= A;
                        b_reg      <= (SUB == ALU_SUB) ? ~B : B;
                        carry_reg  <= (SUB == ALU_SUB) ? 1'b1 : C;
                        result_reg <= '0;
                        digit_cnt  <= '0;
                    end
                end
                alu_pkg::RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_carry;
                    digit_cnt  <= last_digit ? '0 : digit_cnt + 1'b1;
                    if (last_digit) begin
                        sum_reg       <= result_next;
                        carry_out_reg <= slice_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SUM   = sum_reg;
    assign CARRY = carry_out_reg;

`ifdef ADDSUB_FLAGS_EN
    logic zf_reg, nf_reg, vf_reg;

    // Flags follow SUM: they change only on the edge that enters DONE.
    // Overflow uses the effective (possibly inverted) B operand.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            zf_reg <= 1'b0;
            nf_reg <= 1'b0;
            vf_reg <= 1'b0;
        end else if (state == alu_pkg::RUN && last_digit) begin
            zf_reg <= (result_next == '0);
            nf_reg <= result_next[WIDTH-1];
            vf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (result_next[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end

    assign ZF = zf_reg;
    assign NF = nf_reg;
    assign VF = vf_reg;
`else
    assign ZF = 1'b0;
    assign NF = 1'b0;
    assign VF = 1'b0;
`endif

endmodule
